// File: rtl/ft_pkg.sv
// Shared types and constants for the FT2232 frame sequencer.
package ft_pkg;

  // Width of one FT2232 data-bus transfer.
  localparam int FT_BYTE_W = 8;

  // Frame header bytes, most significant byte arrives first.
  localparam logic [31:0] HDR_WORD_DEFAULT = 32'hDDCCBBAA;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OE   = 3'd1,
    ST_HUNT = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_DONE = 3'd5
  } ft_state_e;

  // Header byte expected at match position idx (0 = first byte on the wire).
  function automatic logic [FT_BYTE_W-1:0] hdr_byte(input logic [31:0] word,
                                                    input logic [1:0]  idx);
    logic [FT_BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ft_hdr_match.sv
// Byte-serial header matcher. A byte that breaks a partial match restarts
// the hunt at position 1 when it is itself the first header byte, so a
// header that follows a broken one directly is never missed.
module ft_hdr_match
  import ft_pkg::*;
#(
  parameter logic [31:0] HDR_WORD = HDR_WORD_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 byte_valid_i,
  input  logic [FT_BYTE_W-1:0] byte_i,
  output logic                 match_o,
  output logic                 err_o
);

  logic [1:0] idx_q;
  logic [1:0] idx_d;

  // Match index register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idx_q <= 2'd0;
    else       idx_q <= idx_d;
  end

  // Compare the incoming byte with the expected header byte.
  // match_o fires on the fourth consecutive match; err_o fires only when a
  // partial match (index > 0) is broken, so idle filler bytes are not errors.
  always_comb begin
    idx_d   = idx_q;
    match_o = 1'b0;
    err_o   = 1'b0;
    if (byte_valid_i) begin
      if (byte_i == hdr_byte(HDR_WORD, idx_q)) begin
        if (idx_q == 2'd3) begin
          match_o = 1'b1;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end else begin
        err_o = (idx_q != 2'd0);
        idx_d = (byte_i == hdr_byte(HDR_WORD, 2'd0)) ? 2'd1 : 2'd0;
      end
    end
  end

endmodule

// File: rtl/ft_frame_sequencer.sv
// FT2232 synchronous-FIFO read sequencer: drives OE#/RD#, hunts the frame
// header, assembles big-endian 16-bit pixels and strobes them into the
// reference or live frame buffer.
//
// Byte handshake: the FT2232 offers a byte while rxf_n is low; the byte on
// `data` is taken on any rising edge where the registered rd_n is low and
// rxf_n is low. Nothing else consumes a byte.
module ft_frame_sequencer
  import ft_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int          HEIGHT   = 4,
  parameter int          LOGSIZE  = 4,
  parameter logic [31:0] HDR_WORD = HDR_WORD_DEFAULT
) (
  input  logic                 clock_60_mhz,
  input  logic                 reset,
  input  logic                 rxf_n,
  input  logic [FT_BYTE_W-1:0] data,
  input  logic                 write_btn,
  output logic                 oe_n,
  output logic                 rd_n,
  output logic                 pix_we,
  output logic [LOGSIZE-1:0]   pix_addr,
  output logic [15:0]          pix_data,
  output logic                 pix_ref,
  output logic                 frame_done,
  output logic                 ready,
  output logic [7:0]           hdr_errs
);

  localparam int                 NPIX      = WIDTH * HEIGHT;
  localparam logic [LOGSIZE-1:0] LAST_ADDR = LOGSIZE'(NPIX - 1);
  localparam logic [LOGSIZE-1:0] ADDR_ONE  = LOGSIZE'(1);

  // Sequencer state; kept as a named register so checkers can bind to it.
  ft_state_e state_q, state_d;

  logic                 oe_n_q, oe_n_d;
  logic                 rd_n_q, rd_n_d;
  logic [FT_BYTE_W-1:0] hi_q, hi_d;
  logic                 pix_we_q, pix_we_d;
  logic [LOGSIZE-1:0]   pix_addr_q, pix_addr_d;
  logic [15:0]          pix_data_q, pix_data_d;
  logic                 pix_ref_q, pix_ref_d;
  logic                 frame_done_q, frame_done_d;
  logic                 ready_q, ready_d;
  logic                 ref_done_q, ref_done_d;
  logic [7:0]           hdr_errs_q, hdr_errs_d;
  logic                 ref_pending_q, ref_pending_d;
  logic                 btn_meta_q, btn_sync_q;

  logic accept;
  logic last_pix;
  logic hdr_valid;
  logic hdr_match;
  logic hdr_err;

  assign accept    = ~rd_n_q & ~rxf_n;
  assign last_pix  = (pix_addr_q == LAST_ADDR);
  assign hdr_valid = (state_q == ST_HUNT) && accept;

  ft_hdr_match #(
    .HDR_WORD (HDR_WORD)
  ) u_hdr_match (
    .clk_i        (clock_60_mhz),
    .rst_i        (reset),
    .byte_valid_i (hdr_valid),
    .byte_i       (data),
    .match_o      (hdr_match),
    .err_o        (hdr_err)
  );

  // State register.
  always_ff @(posedge clock_60_mhz or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a pause on rxf_n only stalls the accept signal, so
  // the state is naturally held while the FIFO is empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!rxf_n)    state_d = ST_OE;
      ST_OE:                  state_d = ST_HUNT;
      ST_HUNT: if (hdr_match) state_d = ST_HI;
      ST_HI:   if (accept)    state_d = ST_LO;
      ST_LO:   if (accept)    state_d = last_pix ? ST_DONE : ST_HI;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values. OE# always leads RD# by one cycle:
  // RD# may only drop when OE# was already low on the previous edge.
  always_comb begin
    oe_n_d        = 1'b1;
    rd_n_d        = 1'b1;
    hi_d          = hi_q;
    pix_we_d      = 1'b0;
    pix_data_d    = pix_data_q;
    pix_addr_d    = pix_addr_q;
    pix_ref_d     = pix_ref_q;
    frame_done_d  = 1'b0;
    ready_d       = ready_q;
    ref_done_d    = ref_done_q;
    hdr_errs_d    = hdr_errs_q;
    ref_pending_d = ref_pending_q;

    unique case (state_q)
      ST_IDLE: begin
        oe_n_d = rxf_n;
        rd_n_d = 1'b1;
      end
      ST_DONE: begin
        oe_n_d = 1'b1;
        rd_n_d = 1'b1;
      end
      default: begin
        if (rxf_n) begin
          oe_n_d = 1'b1;
          rd_n_d = 1'b1;
        end else begin
          oe_n_d = 1'b0;
          rd_n_d = oe_n_q;
        end
      end
    endcase

    if (state_q == ST_HI && accept) hi_d = data;

    if (state_q == ST_LO && accept) begin
      pix_we_d   = 1'b1;
      pix_data_d = {hi_q, data};
      if (last_pix) begin
        oe_n_d = 1'b1;
        rd_n_d = 1'b1;
      end
    end

    // Address advances once the write strobe for it has been issued.
    if (state_q == ST_DONE)  pix_addr_d = '0;
    else if (pix_we_q)       pix_addr_d = pix_addr_q + ADDR_ONE;

    if (hdr_match) pix_ref_d = ref_pending_q;

    // A button press wins over the header-match clear so it is never lost.
    if (!btn_sync_q)     ref_pending_d = 1'b1;
    else if (hdr_match)  ref_pending_d = 1'b0;

    if (hdr_err && hdr_errs_q != 8'hFF) hdr_errs_d = hdr_errs_q + 8'd1;

    if (state_q == ST_DONE) begin
      frame_done_d = 1'b1;
      if (pix_ref_q)       ref_done_d = 1'b1;
      else if (ref_done_q) ready_d    = 1'b1;
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge clock_60_mhz or posedge reset) begin
    if (reset) begin
      oe_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      hi_q          <= '0;
      pix_we_q      <= 1'b0;
      pix_addr_q    <= '0;
      pix_data_q    <= '0;
      pix_ref_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      ready_q       <= 1'b0;
      ref_done_q    <= 1'b0;
      hdr_errs_q    <= '0;
      ref_pending_q <= 1'b1;
    end else begin
      oe_n_q        <= oe_n_d;
      rd_n_q        <= rd_n_d;
      hi_q          <= hi_d;
      pix_we_q      <= pix_we_d;
      pix_addr_q    <= pix_addr_d;
      pix_data_q    <= pix_data_d;
      pix_ref_q     <= pix_ref_d;
      frame_done_q  <= frame_done_d;
      ready_q       <= ready_d;
      ref_done_q    <= ref_done_d;
      hdr_errs_q    <= hdr_errs_d;
      ref_pending_q <= ref_pending_d;
    end
  end

  // Two-flop synchroniser for the asynchronous, active-low button.
  always_ff @(posedge clock_60_mhz or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
    end else begin
      btn_meta_q <= write_btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign oe_n       = oe_n_q;
  assign rd_n       = rd_n_q;
  assign pix_we     = pix_we_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign pix_ref    = pix_ref_q;
  assign frame_done = frame_done_q;
  assign ready      = ready_q;
  assign hdr_errs   = hdr_errs_q;

endmodule

// File: tb/tb_ft_frame_sequencer.sv
// Bench for ft_frame_sequencer: FT2232 byte-source model, pixel scoreboard,
// frame-completion checks and a single summary line.
module tb_ft_frame_sequencer;

  localparam int NPIX = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxf_n = 1'b1;
  logic [7:0] data = 8'h00;
  logic       write_btn = 1'b1;

  logic        oe_n, rd_n, pix_we, pix_ref, frame_done, ready;
  logic [3:0]  pix_addr;
  logic [15:0] pix_data;
  logic [7:0]  hdr_errs;

  always #5 clk = ~clk;

  ft_frame_sequencer #(
    .WIDTH    (4),
    .HEIGHT   (4),
    .LOGSIZE  (4),
    .HDR_WORD (32'hDDCCBBAA)
  ) dut (
    .clock_60_mhz (clk),
    .reset        (rst),
    .rxf_n        (rxf_n),
    .data         (data),
    .write_btn    (write_btn),
    .oe_n         (oe_n),
    .rd_n         (rd_n),
    .pix_we       (pix_we),
    .pix_addr     (pix_addr),
    .pix_data     (pix_data),
    .pix_ref      (pix_ref),
    .frame_done   (frame_done),
    .ready        (ready),
    .hdr_errs     (hdr_errs)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_oe_n"},       oe_n,       1);
    check_eq({tag, "_rd_n"},       rd_n,       1);
    check_eq({tag, "_pix_we"},     pix_we,     0);
    check_eq({tag, "_pix_addr"},   pix_addr,   0);
    check_eq({tag, "_pix_data"},   pix_data,   0);
    check_eq({tag, "_pix_ref"},    pix_ref,    0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
    check_eq({tag, "_ready"},      ready,      0);
    check_eq({tag, "_hdr_errs"},   hdr_errs,   0);
  endtask

  // ---------------- FT2232 source model ----------------
  logic [7:0] src_q[$];
  int acc_cnt     = 0;
  int pause_after = -1;
  int pause_left  = 0;

  always @(posedge clk) begin
    if (!rst && !rd_n && !rxf_n) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      acc_cnt++;
      if (acc_cnt == pause_after) pause_left = 5;
    end else if (pause_left > 0) begin
      pause_left--;
    end
    #1;
    rxf_n = (src_q.size() == 0) || (pause_left > 0);
    data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];   // {pix_ref, pix_addr, pix_data}
  logic [0:0]  rdy_q[$];   // expected ready at each frame_done
  logic [20:0] e;
  logic [0:0]  r;
  int wr_in_frame = 0;
  int fd_cnt      = 0;
  logic prev_rd_n = 1'b1;
  logic prev_oe_n = 1'b1;
  bit   m_ref_done = 0;
  bit   m_ready    = 0;

  always @(negedge clk) begin
    if (pix_we) begin
      check_eq("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("pix_data", pix_data, e[15:0]);
        check_eq("pix_addr", pix_addr, e[19:16]);
        check_eq("pix_ref",  pix_ref,  e[20]);
      end
      wr_in_frame++;
    end
    if (frame_done) begin
      fd_cnt++;
      check_eq("frame_writes", wr_in_frame, NPIX);
      check_eq("done_addr", pix_addr, 0);
      check_eq("done_rd_n", rd_n, 1);
      check_eq("done_expected", rdy_q.size() > 0, 1);
      if (rdy_q.size() > 0) begin
        r = rdy_q.pop_front();
        check_eq("ready", ready, r);
      end
      wr_in_frame = 0;
    end
    if (pause_left inside {[1:4]}) begin
      check_eq("pause_rd_n", rd_n, 1);
      check_eq("pause_oe_n", oe_n, 1);
    end
    if (prev_rd_n && !rd_n) check_eq("oe_before_rd", prev_oe_n, 0);
    prev_rd_n = rd_n;
    prev_oe_n = oe_n;
  end

  // ---------------- driver tasks ----------------
  task automatic push_hdr();
    src_q.push_back(8'hDD);
    src_q.push_back(8'hCC);
    src_q.push_back(8'hBB);
    src_q.push_back(8'hAA);
  endtask

  // mode 0: (i+1)*1000 with a zero last pixel; 1: 03E3 + i*03EA;
  // 2: 1234 ^ i*0101; 3: random.
  task automatic queue_pixels(input bit exp_ref, input int mode);
    logic [15:0] v;
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0:       v = (i < NPIX - 1) ? 16'((i + 1) * 1000) : 16'h0000;
        1:       v = 16'h03E3 + 16'(i * 16'h03EA);
        2:       v = 16'h1234 ^ 16'(i * 16'h0101);
        default: v = 16'($urandom_range(0, 65535));
      endcase
      src_q.push_back(v[15:8]);
      src_q.push_back(v[7:0]);
      exp_q.push_back({exp_ref, 4'(i), v});
    end
    if (exp_ref)         m_ref_done = 1;
    else if (m_ref_done) m_ready    = 1;
    rdy_q.push_back(m_ready);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (fd_cnt >= target) break;
    end
    check_eq("wait_frame_done", fd_cnt >= target, 1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (wr_in_frame >= target) break;
    end
    check_eq("wait_writes", wr_in_frame >= target, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset("rst0");
    @(negedge clk) rst = 1'b0;

    // Frame A: idle zero bytes, header, reference capture after reset.
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) src_q.push_back(8'h00);
    push_hdr();
    queue_pixels(1'b1, 0);
    wait_done(1, 600);
    check_eq("hdr_errs_a", hdr_errs, 0);

    // Frame B: live frame, ready rises with its completion.
    push_hdr();
    queue_pixels(1'b0, 1);
    wait_done(2, 600);

    // Frame C: trailing bytes, broken header, pause after pixel 6 high byte,
    // button press mid-frame.
    acc_cnt     = 0;
    pause_after = 22;
    src_q.push_back(8'h55);
    src_q.push_back(8'h66);
    src_q.push_back(8'hDD);
    src_q.push_back(8'hCC);
    src_q.push_back(8'h11);
    push_hdr();
    queue_pixels(1'b0, 2);
    wait_writes(3, 600);
    @(posedge clk);
    #1 write_btn = 1'b0;
    repeat (4) @(posedge clk);
    #1 write_btn = 1'b1;
    wait_done(3, 800);
    check_eq("hdr_errs_c", hdr_errs, 1);
    pause_after = -1;

    // Frame D: reference (button), aborted by reset at pixel 9.
    push_hdr();
    queue_pixels(1'b1, 3);
    wait_writes(9, 600);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("rst_mid");
    src_q.delete();
    exp_q.delete();
    rdy_q.delete();
    wr_in_frame = 0;
    pause_left  = 0;
    acc_cnt     = 0;
    m_ref_done  = 0;
    m_ready     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Frame E: fresh reset forces reference capture from address 0.
    push_hdr();
    queue_pixels(1'b1, 3);
    wait_done(4, 600);
    check_eq("hdr_errs_e", hdr_errs, 0);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("frame_count", fd_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
